// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryptor: one round per clock with on-the-fly key expansion.
// Optional macro AES_LAST_RK_OUT_EN exposes round key 10 as last_round_key.
module aes128_encrypt_iter (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [0:127]   plaintext,
  input  logic [0:127]   key,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [0:127]   ciphertext
`ifdef AES_LAST_RK_OUT_EN
  ,
  output logic [0:127]   last_round_key
`endif
);

  // Forward S-box, entry x at bits [8*x +: 8].
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {StIdle, StRun, StDone} st_e;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[8*int'(x) +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [0:127] sub_bytes(input logic [0:127] s);
    logic [0:127] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  // Byte (row r, column c) sits at index r + 4*c; row r rotates left by r columns.
  function automatic logic [0:127] shift_rows(input logic [0:127] s);
    logic [0:127] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(r+4*c) +: 8] = s[8*(r+4*((c+r)%4)) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [0:127] mix_columns(input logic [0:127] s);
    logic [0:127] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c      +: 8];
      a1 = s[32*c + 8  +: 8];
      a2 = s[32*c + 16 +: 8];
      a3 = s[32*c + 24 +: 8];
      o[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [0:127] key_expand(input logic [0:127] rk, input logic [7:0] rc);
    logic [0:127] o;
    logic [0:31]  w3, t;
    w3 = rk[96 +: 32];
    t  = {sbox(w3[8 +: 8]) ^ rc, sbox(w3[16 +: 8]), sbox(w3[24 +: 8]), sbox(w3[0 +: 8])};
    o[0  +: 32] = rk[0  +: 32] ^ t;
    o[32 +: 32] = rk[32 +: 32] ^ o[0  +: 32];
    o[64 +: 32] = rk[64 +: 32] ^ o[32 +: 32];
    o[96 +: 32] = rk[96 +: 32] ^ o[64 +: 32];
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  st_e          st_q;
  logic [3:0]   rnd_q;
  logic [0:127] state_q, rk_q;
  logic [0:127] rk_next, shifted, round_out, final_out;

  always_comb begin
    rk_next   = key_expand(rk_q, rcon(rnd_q));
    shifted   = shift_rows(sub_bytes(state_q));
    round_out = mix_columns(shifted) ^ rk_next;
    final_out = shifted ^ rk_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= StIdle;
      rnd_q      <= 4'd0;
      state_q    <= '0;
      rk_q       <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      ciphertext <= '0;
`ifdef AES_LAST_RK_OUT_EN
      last_round_key <= '0;
`endif
    end else begin
      case (st_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            state_q  <= plaintext ^ key;
            rk_q     <= key;
            rnd_q    <= 4'd1;
            in_ready <= 1'b0;
            st_q     <= StRun;
          end
        end
        StRun: begin
          if (rnd_q >= 4'd1 && rnd_q <= 4'd9) begin
            state_q <= round_out;
            rk_q    <= rk_next;
            rnd_q   <= rnd_q + 4'd1;
          end else if (rnd_q == 4'd10) begin
            ciphertext <= final_out;
`ifdef AES_LAST_RK_OUT_EN
            last_round_key <= rk_next;
`endif
            rnd_q     <= 4'd0;
            out_valid <= 1'b1;
            st_q      <= StDone;
          end else begin
            // Unreachable round count: abandon the block.
            rnd_q    <= 4'd0;
            in_ready <= 1'b1;
            st_q     <= StIdle;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            st_q      <= StIdle;
          end
        end
        default: begin
          rnd_q     <= 4'd0;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          st_q      <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Bench for aes128_encrypt_iter: FIPS-197 vectors plus random blocks against a
// GF(2^8)-arithmetic AES reference model.
module tb_aes128_encrypt_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [127:0] plaintext, key, ciphertext;
`ifdef AES_LAST_RK_OUT_EN
  logic [127:0] last_round_key;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  aes128_encrypt_iter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext)
`ifdef AES_LAST_RK_OUT_EN
    ,
    .last_round_key (last_round_key)
`endif
  );

  // ---------------- reference model ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
    return (v << k) | (v >> (8 - k));
  endfunction

  task automatic init_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic aes_ref(input logic [127:0] k, input logic [127:0] p,
                         output logic [127:0] ct, output logic [127:0] rk10);
    logic [7:0]  s [4][4];
    logic [7:0]  t [4][4];
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    logic [7:0]  cf [4];
    logic [7:0]  acc;
    cf = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = p[127-8*(r+4*c) -: 8] ^ w[c][31-8*r -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r][c] = sb[s[r][c]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) s[r][c] = t[r][(c+r)%4];
      if (rd < 10) begin
        t = s;
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc ^= gmul(cf[(j-r+4)%4], t[j][c]);
            s[r][c] = acc;
          end
      end
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) s[r][c] ^= w[4*rd+c][31-8*r -: 8];
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) ct[127-8*(r+4*c) -: 8] = s[r][c];
    rk10 = {w[40], w[41], w[42], w[43]};
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Starts at a negedge with the engine idle; returns at a negedge after the output handshake.
  task automatic run_block(input string tag, input logic [127:0] k, input logic [127:0] p,
                           input logic [127:0] exp_ct, input logic [127:0] exp_rk,
                           input int stall, input bit noisy);
    int cycles;
    logic [127:0] held;
    chk({tag, " idle in_ready"}, 128'(in_ready), 128'd1);
    in_valid  = 1'b1;
    plaintext = p;
    key       = k;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, " in_ready after accept"}, 128'(in_ready), 128'd0);
    if (noisy) begin
      plaintext = rnd128();
      key       = rnd128();
      out_ready = 1'($urandom);
    end else begin
      in_valid = 1'b0;
    end
    cycles = 0;
    while (cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (out_valid) break;
      if (noisy) begin
        plaintext = rnd128();
        key       = rnd128();
        out_ready = 1'($urandom);
      end
    end
    out_ready = 1'b0;
    chk({tag, " latency"}, 128'(cycles), 128'd10);
    chk({tag, " ciphertext"}, ciphertext, exp_ct);
`ifdef AES_LAST_RK_OUT_EN
    chk({tag, " last_round_key"}, last_round_key, exp_rk);
`else
    if (exp_rk === 128'hx) $display("unexpected unknown round key");
`endif
    held = ciphertext;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, " stall ct"}, ciphertext, held);
      chk({tag, " stall in_ready"}, 128'(in_ready), 128'd0);
      chk({tag, " stall out_valid"}, 128'(out_valid), 128'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, " out_valid after hs"}, 128'(out_valid), 128'd0);
    chk({tag, " in_ready after hs"}, 128'(in_ready), 128'd1);
  endtask

  localparam logic [127:0] KeyB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PtB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CtB  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] RkB  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KeyC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PtC  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CtC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    logic [127:0] k, p, ect, erk, rkc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    plaintext = '0;
    key       = '0;
    init_sbox();

    // Held in reset with inputs toggling.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      plaintext = rnd128();
      key       = rnd128();
      #1;
      chk("reset in_ready", 128'(in_ready), 128'd1);
      chk("reset out_valid", 128'(out_valid), 128'd0);
      chk("reset ciphertext", ciphertext, 128'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);

    aes_ref(KeyC, PtC, ect, rkc);
    run_block("appB", KeyB, PtB, CtB, RkB, 0, 1'b0);
    run_block("appC stall", KeyC, PtC, CtC, rkc, 20, 1'b0);
    run_block("appB noisy", KeyB, PtB, CtB, RkB, 2, 1'b1);
    run_block("appC b2b", KeyC, PtC, CtC, rkc, 0, 1'b0);

    for (int n = 0; n < 6; n++) begin
      k = rnd128();
      p = rnd128();
      aes_ref(k, p, ect, erk);
      run_block("random", k, p, ect, erk, int'($urandom_range(0, 3)), 1'($urandom));
    end

    // Reset around round 5 discards the block immediately.
    in_valid  = 1'b1;
    plaintext = PtC;
    key       = KeyC;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset out_valid", 128'(out_valid), 128'd0);
    chk("midreset in_ready", 128'(in_ready), 128'd1);
    chk("midreset ciphertext", ciphertext, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_block("appB after reset", KeyB, PtB, CtB, RkB, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
